// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start and operands; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one borrow-chain stage per clock, start/done handshake.
// {borrow_out, diff} = {1'b0, a} - {1'b0, b}, result registered on the done cycle.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;

  logic               ai, bi, di, br_next;

  // Single full-subtractor stage on the current LSBs.
  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0];
    di      = ai ^ bi ^ br_q;
    br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {di, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CNT_W'(1);
        // The stage with cnt_q == WIDTH-1 is the MSB, so WIDTH stages run in total.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d   = 1'b1;
        diff_d   = res_q;
        borrow_d = br_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 (directed + random) and WIDTH=8 (random).
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start_drv;
  logic [7:0] a_drv;
  logic [7:0] b_drv;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] hist_a [0:8191];
  logic [7:0] hist_b [0:8191];

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  assign if4.start = start_drv;
  assign if4.a     = a_drv[3:0];
  assign if4.b     = b_drv[3:0];
  assign if8.start = start_drv;
  assign if8.a     = a_drv;
  assign if8.b     = b_drv;

  serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned subtraction in integers; returns {borrow, diff}.
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input int w);
    int mask;
    int d;
    mask = (1 << w) - 1;
    d    = int'(a) & mask;
    d    = d - (int'(b) & mask);
    ref_sub = {(d < 0), 8'(d & mask)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    hist_a[cyc] = a_drv;
    hist_b[cyc] = b_drv;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One WIDTH=4 operation: latency, result and 5 idle cycles of hold.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input string tag);
    logic [8:0] exp;
    int n;
    exp       = ref_sub({4'd0, a}, {4'd0, b}, 4);
    a_drv     = {4'd0, a};
    b_drv     = {4'd0, b};
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    a_drv     = 8'($urandom);
    b_drv     = 8'($urandom);
    n = 1;
    while (if4.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd6);
    chk({tag, "_diff"}, 32'(if4.diff), 32'(exp[3:0]));
    chk({tag, "_borrow"}, 32'(if4.borrow_out), 32'(exp[8]));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_hold_done"}, 32'(if4.done), 32'd0);
      chk({tag, "_hold_busy"}, 32'(if4.busy), 32'd0);
      chk({tag, "_hold_diff"}, 32'(if4.diff), 32'(exp[3:0]));
      chk({tag, "_hold_borrow"}, 32'(if4.borrow_out), 32'(exp[8]));
    end
  endtask

  initial begin
    int ndone;
    int n4, n8, last4, last8, idx;
    logic [8:0] exp;

    rst       = 1'b1;
    start_drv = 1'b0;
    a_drv     = '0;
    b_drv     = '0;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      a_drv = 8'($urandom);
      b_drv = 8'($urandom);
      tick();
      chk("idle_busy", 32'(if4.busy), 32'd0);
      chk("idle_done", 32'(if4.done), 32'd0);
      chk("idle_diff", 32'(if4.diff), 32'd0);
      chk("idle_borrow", 32'(if4.borrow_out), 32'd0);
    end

    run_op(4'd9,  4'd3,  "op_9_3");
    run_op(4'd3,  4'd9,  "op_3_9");
    run_op(4'd0,  4'd1,  "op_0_1");
    run_op(4'd15, 4'd15, "op_15_15");

    // Start pulse during SHIFT must be ignored.
    a_drv     = 8'd12;
    b_drv     = 8'd5;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    tick();
    a_drv     = 8'd3;
    b_drv     = 8'd9;
    start_drv = 1'b1;
    chk("ign_busy", 32'(if4.busy), 32'd1);
    tick();
    start_drv = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if4.done === 1'b1) begin
        ndone++;
        chk("ign_diff", 32'(if4.diff), 32'd7);
        chk("ign_borrow", 32'(if4.borrow_out), 32'd0);
      end
    end
    chk("ign_done_count", 32'(ndone), 32'd1);

    // Reset in the middle of SHIFT aborts the operation.
    a_drv     = 8'd8;
    b_drv     = 8'd2;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(if4.busy), 32'd0);
    chk("abort_done", 32'(if4.done), 32'd0);
    chk("abort_diff", 32'(if4.diff), 32'd0);
    chk("abort_borrow", 32'(if4.borrow_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if4.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(4'd5, 4'd5, "op_5_5");

    // Back-to-back random operations, both widths, start held high.
    rst = 1'b1;
    tick();
    tick();
    rst       = 1'b0;
    start_drv = 1'b1;
    n4 = 0; n8 = 0; last4 = -1; last8 = -1;
    for (int i = 0; i < 3000 && (n4 < 200 || n8 < 200); i++) begin
      a_drv = 8'($urandom);
      b_drv = 8'($urandom);
      tick();
      if (if4.done === 1'b1) begin
        idx = cyc - 4 - 2;
        exp = ref_sub(hist_a[idx], hist_b[idx], 4);
        chk("rnd4_diff", 32'(if4.diff), 32'(exp[3:0]));
        chk("rnd4_borrow", 32'(if4.borrow_out), 32'(exp[8]));
        if (last4 >= 0) chk("rnd4_spacing", 32'(cyc - last4), 32'd6);
        last4 = cyc;
        n4++;
      end
      if (if8.done === 1'b1) begin
        idx = cyc - 8 - 2;
        exp = ref_sub(hist_a[idx], hist_b[idx], 8);
        chk("rnd8_diff", 32'(if8.diff), 32'(exp[7:0]));
        chk("rnd8_borrow", 32'(if8.borrow_out), 32'(exp[8]));
        if (last8 >= 0) chk("rnd8_spacing", 32'(cyc - last8), 32'd10);
        last8 = cyc;
        n8++;
      end
    end
    start_drv = 1'b0;
    chk("rnd_op_count", 32'((n4 >= 200) && (n8 >= 200)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first W-bit subtractor computing diff = a − b with a borrow-out.
- It is the inverse-direction companion to the parallel ripple-carry adder datapath, and reuses the same full-adder sum function with a borrow-generate term in place of carry-generate.
- It trades latency for area: one borrow-chain stage is evaluated per clock using a start/done handshake.
- It serves the arithmetic unit wherever a subtract is needed without a second parallel adder.

Parameters:
- WIDTH, 4, operand and result width in bits (valid range 2..32)

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a subtraction; sampled only when the block is idle
- a  input  WIDTH  minuend, captured on an accepted start
- b  input  WIDTH  subtrahend, captured on an accepted start
- busy  output  1  high while a subtraction is in progress (SHIFT and DONE states)
- done  output  1  one-cycle pulse; diff and borrow_out are valid from this cycle onward
- diff  output  WIDTH  result a − b, modulo 2^WIDTH
- borrow_out  output  1  1 when a < b (unsigned)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high; all state changes occur on the rising edge of `clk`.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, borrow_out = 0
  - internal operand registers, result shift register, borrow register and bit counter all = 0
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: capture a and b into shift registers, set borrow register to 0, set counter to 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per cycle:
  - Take ai = LSB of the a shift register, bi = LSB of the b shift register, br = borrow register.
  - di = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift di into the MSB of the result shift register (right shift).
  - Shift both operand registers right by one.
  - Increment the counter.
  - When the counter reaches WIDTH−1 on this edge, go to DONE. This gives exactly WIDTH SHIFT cycles.
- DONE, one cycle:
  - done = 1.
  - Transfer the result shift register to diff and the borrow register to borrow_out. These values are registered and become visible in the same cycle as done=1.
  - Go to IDLE.
- Latency: start accepted at edge k → done=1 during the cycle after edge k+WIDTH+1. Total is WIDTH+2 edges from the accepting edge to done.
- Result hold: diff and borrow_out keep their values until the next DONE or until rst; they do not change during SHIFT.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- Earliest next start is the first cycle in IDLE after done.
- start while busy: ignored. Operands are not re-captured, the counter is unaffected, and no error is flagged.
- start held high continuously: a new operation begins on each return to IDLE, i.e. one result every WIDTH+2 cycles.
- Reset mid-operation (SHIFT or DONE): the operation is aborted. All outputs return to their reset values on the next edge, and no done pulse is produced.
- Arithmetic:
  - diff equals (a − b) mod 2^WIDTH.
  - borrow_out equals (a < b) unsigned.
  - Equivalently, {borrow_out, diff} = {1'b0, a} − {1'b0, b} in WIDTH+1 bits, two's complement.
- a and b are don't-care except on the accepting edge.

Test Plan:
1. Reset then idle, start=0 for 10 cycles → busy=0, done=0, diff=0, borrow_out=0 throughout.
2. WIDTH=4, a=9, b=3, start pulse → done exactly WIDTH+2 edges later; diff=6, borrow_out=0; values hold for 5 further idle cycles.
3. WIDTH=4, edge cases:
   - a=3, b=9 → diff=4'b1010 (10), borrow_out=1.
   - a=0, b=1 → diff=15, borrow_out=1.
   - a=15, b=15 → diff=0, borrow_out=0.
4. Start a=12, b=5; change a/b and pulse start at SHIFT cycle 2 → second start ignored; result diff=7, borrow_out=0; single done pulse.
5. Start a=8, b=2, assert rst at SHIFT cycle 3 → next cycle busy=0, diff=0, borrow_out=0, no done. Then start a=5, b=5 → diff=0, borrow_out=0.
6. start held high with random a/b for 200 operations (WIDTH=4 and WIDTH=8) → every done matches the reference model {borrow,diff} = a−b; done spacing is exactly WIDTH+2 cycles.
